// File: rtl/fp_add_arbiter_if.sv
// rtl/fp_add_arbiter_if.sv - requester, adder and response signals of the shared FP adder arbiter
interface fp_add_arbiter_if #(
    parameter int DATA_WIDTH = 32
);
    logic                  req0_valid;
    logic                  req1_valid;
    logic [DATA_WIDTH-1:0] req0_a;
    logic [DATA_WIDTH-1:0] req0_b;
    logic [DATA_WIDTH-1:0] req1_a;
    logic [DATA_WIDTH-1:0] req1_b;
    logic                  req0_ready;
    logic                  req1_ready;
    logic                  add_valid_in;
    logic [DATA_WIDTH-1:0] add_in1;
    logic [DATA_WIDTH-1:0] add_in2;
    logic                  add_valid_out;
    logic [DATA_WIDTH-1:0] add_result;
    logic                  rsp0_valid;
    logic                  rsp1_valid;
    logic [DATA_WIDTH-1:0] rsp0_data;
    logic [DATA_WIDTH-1:0] rsp1_data;
    logic                  busy;
    logic                  err;

    modport slave (
        input  req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        input  add_valid_out, add_result,
        output req0_ready, req1_ready, add_valid_in, add_in1, add_in2,
        output rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, busy, err
    );

    modport master (
        output req0_valid, req1_valid, req0_a, req0_b, req1_a, req1_b,
        output add_valid_out, add_result,
        input  req0_ready, req1_ready, add_valid_in, add_in1, add_in2,
        input  rsp0_valid, rsp1_valid, rsp0_data, rsp1_data, busy, err
    );
endinterface

// File: rtl/fp_add_arbiter.sv
// rtl/fp_add_arbiter.sv - two-requester round-robin front end for a fixed-latency shared FP adder
module fp_add_arbiter #(
    parameter int DATA_WIDTH  = 32,
    parameter int ADD_LATENCY = 7
) (
    input  logic             clk,
    input  logic             reset,
    fp_add_arbiter_if.slave  bus
);
    logic                   ptr;
    logic                   grant0;
    logic                   grant1;
    logic                   issue_valid;
    logic                   issue_id;
    logic [DATA_WIDTH-1:0]  issue_a;
    logic [DATA_WIDTH-1:0]  issue_b;
    logic [ADD_LATENCY-1:0] tag_valid;
    logic [ADD_LATENCY-1:0] tag_id;
    logic                   rsp0_valid_q;
    logic                   rsp1_valid_q;
    logic [DATA_WIDTH-1:0]  rsp0_data_q;
    logic [DATA_WIDTH-1:0]  rsp1_data_q;
    logic                   err_q;

    // A lone requester wins regardless of the pointer; the pointer only breaks ties.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (!reset) begin
            grant0 = bus.req0_valid && (!bus.req1_valid || !ptr);
            grant1 = bus.req1_valid && (!bus.req0_valid ||  ptr);
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ptr          <= 1'b0;
            issue_valid  <= 1'b0;
            issue_id     <= 1'b0;
            issue_a      <= '0;
            issue_b      <= '0;
            tag_valid    <= '0;
            tag_id       <= '0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_data_q  <= '0;
            rsp1_data_q  <= '0;
            err_q        <= 1'b0;
        end else begin
            issue_valid <= grant0 || grant1;
            if (grant0 || grant1) begin
                issue_a  <= grant1 ? bus.req1_a : bus.req0_a;
                issue_b  <= grant1 ? bus.req1_b : bus.req0_b;
                issue_id <= grant1;
                ptr      <= grant0;
            end

            // Tag stage 0 follows the issue register so the last stage lines up with add_valid_out.
            tag_valid[0] <= issue_valid;
            tag_id[0]    <= issue_id;
            for (int i = 1; i < ADD_LATENCY; i++) begin
                tag_valid[i] <= tag_valid[i-1];
                tag_id[i]    <= tag_id[i-1];
            end

            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            if (tag_valid[ADD_LATENCY-1] && bus.add_valid_out) begin
                if (tag_id[ADD_LATENCY-1]) begin
                    rsp1_valid_q <= 1'b1;
                    rsp1_data_q  <= bus.add_result;
                end else begin
                    rsp0_valid_q <= 1'b1;
                    rsp0_data_q  <= bus.add_result;
                end
            end
            if (tag_valid[ADD_LATENCY-1] != bus.add_valid_out) begin
                err_q <= 1'b1;
            end
        end
    end

    assign bus.req0_ready   = grant0;
    assign bus.req1_ready   = grant1;
    assign bus.add_valid_in = issue_valid;
    assign bus.add_in1      = issue_a;
    assign bus.add_in2      = issue_b;
    assign bus.rsp0_valid   = rsp0_valid_q;
    assign bus.rsp1_valid   = rsp1_valid_q;
    assign bus.rsp0_data    = rsp0_data_q;
    assign bus.rsp1_data    = rsp1_data_q;
    assign bus.err          = err_q;
    assign bus.busy         = issue_valid || (|tag_valid) || rsp0_valid_q || rsp1_valid_q;
endmodule

// File: tb/tb_fp_add_arbiter.sv
// tb/tb_fp_add_arbiter.sv - randomized bench with behavioural arbiter/adder model for fp_add_arbiter
module tb_fp_add_arbiter;
    localparam int L = 7;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic inj = 1'b0;
    logic model_av = 1'b0;
    logic [31:0] model_res = '0;

    int total = 0;
    int bad = 0;
    int cyc = 0;

    fp_add_arbiter_if #(.DATA_WIDTH(32)) bus ();

    fp_add_arbiter #(.DATA_WIDTH(32), .ADD_LATENCY(L)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    assign bus.add_valid_out = model_av | inj;
    assign bus.add_result    = model_res;

    function automatic real f2r(input logic [31:0] f);
        logic [10:0] e;
        if (f[30:23] == 8'd0) return 0.0;
        e = {3'b000, f[30:23]} + 11'd896;
        return $bitstoreal({f[31], e, f[22:0], 29'd0});
    endfunction

    function automatic logic [31:0] r2f(input real r);
        logic [63:0] d;
        logic [10:0] e;
        if (r == 0.0) return 32'd0;
        d = $realtobits(r);
        e = d[62:52] - 11'd896;
        return {d[63], e[7:0], d[51:29]};
    endfunction

    function automatic logic [31:0] fadd(input logic [31:0] a, input logic [31:0] b);
        return r2f(f2r(a) + f2r(b));
    endfunction

    function automatic logic [31:0] rand_fp();
        int n;
        n = int'($urandom_range(1, 1023));
        if ($urandom_range(0, 1) == 1) n = -n;
        return r2f(real'(n));
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h at %0t", name, act, exp, $time);
        end
    endtask

    // External adder: fixed latency L, result visible in the cycle L after add_valid_in.
    logic        pv [0:L];
    logic [31:0] pd [0:L];
    initial for (int i = 0; i <= L; i++) begin pv[i] = 1'b0; pd[i] = '0; end

    always @(posedge clk) begin
        #1;
        for (int i = L; i > 0; i--) begin
            pv[i] = pv[i-1];
            pd[i] = pd[i-1];
        end
        pv[0] = bus.add_valid_in;
        pd[0] = fadd(bus.add_in1, bus.add_in2);
        if (reset) for (int i = 0; i <= L; i++) pv[i] = 1'b0;
        model_av  = pv[L];
        model_res = pd[L];
    end

    // Reference model of the arbiter: pointer, issue register, ordered response schedule.
    typedef struct {
        int          due;
        bit          id;
        logic [31:0] data;
    } rsp_t;

    rsp_t        q[$];
    bit          m_ptr = 1'b0;
    bit          iss_v = 1'b0;
    logic [31:0] iss_a = '0;
    logic [31:0] iss_b = '0;
    logic [31:0] last0 = '0;
    logic [31:0] last1 = '0;
    bit          err_exp = 1'b0;

    always @(negedge clk) begin
        bit e0, e1, rv0, rv1;
        if (reset) begin
            chk("rst_ready0", {31'd0, bus.req0_ready}, 32'd0);
            chk("rst_ready1", {31'd0, bus.req1_ready}, 32'd0);
            chk("rst_add_valid_in", {31'd0, bus.add_valid_in}, 32'd0);
            chk("rst_add_in1", bus.add_in1, 32'd0);
            chk("rst_add_in2", bus.add_in2, 32'd0);
            chk("rst_rsp_valid", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
            chk("rst_rsp0_data", bus.rsp0_data, 32'd0);
            chk("rst_rsp1_data", bus.rsp1_data, 32'd0);
            chk("rst_busy", {31'd0, bus.busy}, 32'd0);
            chk("rst_err", {31'd0, bus.err}, 32'd0);
            q.delete();
            m_ptr = 1'b0; iss_v = 1'b0; iss_a = '0; iss_b = '0;
            last0 = '0; last1 = '0; err_exp = 1'b0;
        end else begin
            e0 = bus.req0_valid && (!bus.req1_valid || m_ptr == 1'b0);
            e1 = bus.req1_valid && (!bus.req0_valid || m_ptr == 1'b1);
            chk("ready0", {31'd0, bus.req0_ready}, {31'd0, e0});
            chk("ready1", {31'd0, bus.req1_ready}, {31'd0, e1});
            chk("add_valid_in", {31'd0, bus.add_valid_in}, {31'd0, iss_v});
            chk("add_in1", bus.add_in1, iss_a);
            chk("add_in2", bus.add_in2, iss_b);
            chk("busy", {31'd0, bus.busy}, {31'd0, q.size() != 0});
            rv0 = 1'b0; rv1 = 1'b0;
            if (q.size() != 0 && q[0].due == cyc) begin
                if (q[0].id) begin rv1 = 1'b1; last1 = q[0].data; end
                else         begin rv0 = 1'b1; last0 = q[0].data; end
                void'(q.pop_front());
            end
            chk("rsp0_valid", {31'd0, bus.rsp0_valid}, {31'd0, rv0});
            chk("rsp1_valid", {31'd0, bus.rsp1_valid}, {31'd0, rv1});
            chk("rsp0_data", bus.rsp0_data, last0);
            chk("rsp1_data", bus.rsp1_data, last1);
            chk("err", {31'd0, bus.err}, {31'd0, err_exp});
            if (inj) err_exp = 1'b1;
            iss_v = e0 || e1;
            if (e0 || e1) begin
                iss_a = e1 ? bus.req1_a : bus.req0_a;
                iss_b = e1 ? bus.req1_b : bus.req0_b;
                q.push_back('{due: cyc + 2 + L, id: e1, data: fadd(iss_a, iss_b)});
                m_ptr = e0;
            end
        end
        cyc++;
    end

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    // Latency in cycles from a drive made at posedge+1 to the first rsp pulse of each id.
    task automatic watch(input time t0, output int l0, output int l1, output logic [31:0] d0);
        l0 = -1; l1 = -1; d0 = '0;
        for (int n = 0; n < 25; n++) begin
            @(negedge clk);
            if (bus.rsp0_valid && l0 < 0) begin l0 = int'(($time - t0 - 4) / 10); d0 = bus.rsp0_data; end
            if (bus.rsp1_valid && l1 < 0) l1 = int'(($time - t0 - 4) / 10);
        end
    endtask

    initial begin
        time t0;
        int  l0, l1;
        logic [31:0] d0;

        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        bus.req0_a = '0; bus.req0_b = '0; bus.req1_a = '0; bus.req1_b = '0;
        repeat (2) next_cycle();
        reset = 1'b0;
        next_cycle();

        // Single 1.0 + 2.0 from requester 0
        bus.req0_valid = 1'b1; bus.req0_a = 32'h3F800000; bus.req0_b = 32'h40000000;
        t0 = $time;
        next_cycle();
        bus.req0_valid = 1'b0;
        watch(t0, l0, l1, d0);
        chk("single_lat0", l0, 32'd9);
        chk("single_data0", d0, 32'h40400000);
        chk("single_no_rsp1", l1, 32'hFFFFFFFF);

        // Contention straight out of reset
        next_cycle();
        reset = 1'b1;
        bus.req0_valid = 1'b1; bus.req0_a = rand_fp(); bus.req0_b = rand_fp();
        bus.req1_valid = 1'b1; bus.req1_a = rand_fp(); bus.req1_b = rand_fp();
        repeat (2) next_cycle();
        reset = 1'b0;
        t0 = $time;
        @(negedge clk);
        chk("cont_ready0_t", {31'd0, bus.req0_ready}, 32'd1);
        chk("cont_ready1_t", {31'd0, bus.req1_ready}, 32'd0);
        next_cycle();
        bus.req0_valid = 1'b0;
        @(negedge clk);
        chk("cont_ready1_t1", {31'd0, bus.req1_ready}, 32'd1);
        next_cycle();
        bus.req1_valid = 1'b0;
        watch(t0, l0, l1, d0);
        chk("cont_lat0", l0, 32'd9);
        chk("cont_lat1", l1, 32'd10);

        // Streaming: both requesters valid for eight cycles
        next_cycle();
        for (int i = 0; i < 8; i++) begin
            bus.req0_valid = 1'b1; bus.req0_a = rand_fp(); bus.req0_b = rand_fp();
            bus.req1_valid = 1'b1; bus.req1_a = rand_fp(); bus.req1_b = rand_fp();
            @(negedge clk);
            chk("stream_grant", {31'd0, bus.req1_ready}, i % 2);
            next_cycle();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        repeat (15) next_cycle();

        // Bubbles on requester 1
        for (int i = 0; i < 3; i++) begin
            bus.req1_valid = (i != 1); bus.req1_a = rand_fp(); bus.req1_b = rand_fp();
            next_cycle();
        end
        bus.req1_valid = 1'b0;
        repeat (15) next_cycle();

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            bus.req0_valid = ($urandom_range(0, 9) < 6);
            bus.req1_valid = ($urandom_range(0, 9) < 6);
            bus.req0_a = rand_fp(); bus.req0_b = rand_fp();
            bus.req1_a = rand_fp(); bus.req1_b = rand_fp();
            next_cycle();
        end
        bus.req0_valid = 1'b0; bus.req1_valid = 1'b0;
        repeat (15) next_cycle();

        // Reset with three operations in flight
        for (int i = 0; i < 3; i++) begin
            bus.req0_valid = 1'b1; bus.req0_a = rand_fp(); bus.req0_b = rand_fp();
            next_cycle();
        end
        bus.req0_valid = 1'b0;
        repeat (4) next_cycle();
        reset = 1'b1;
        #1;
        chk("midrst_busy", {31'd0, bus.busy}, 32'd0);
        chk("midrst_add_valid_in", {31'd0, bus.add_valid_in}, 32'd0);
        chk("midrst_rsp", {30'd0, bus.rsp1_valid, bus.rsp0_valid}, 32'd0);
        repeat (2) next_cycle();
        reset = 1'b0;
        repeat (15) next_cycle();

        // Spurious adder result with no tag in flight
        inj = 1'b1;
        next_cycle();
        inj = 1'b0;
        repeat (5) next_cycle();
        @(negedge clk);
        chk("err_sticky", {31'd0, bus.err}, 32'd1);
        next_cycle();
        reset = 1'b1;
        next_cycle();
        @(negedge clk);
        chk("err_cleared", {31'd0, bus.err}, 32'd0);
        next_cycle();
        reset = 1'b0;
        repeat (3) next_cycle();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
